// File: rtl/uart_fifo_param.sv
// ---------------------------------------------------------------------------
// uart_fifo_param
//
// Purpose:
//   Parametrised single-clock byte/entry buffer for the UART transmit and
//   receive paths. It is a first-word fall-through FIFO with an occupancy
//   count, a synchronous flush, sticky overrun/underrun flags that are cleared
//   on request, and a programmable fill-level trigger. Receive-side instances
//   set DATA_W=11 so that each entry carries {bi, fe, pe, data[7:0]}.
//
// Parameters:
//   DATA_W : entry width in bits (>= 1)
//   DEPTH  : number of entries, a power of two (>= 2)
//   CNT_W  : width of count/threshold; derived, do not override
//
// Ports:
//   clk          in   1       system clock, rising edge
//   rst          in   1       synchronous active-high reset
//   en           in   1       FIFO enable; when low, push/pop are ignored
//   flush        in   1       synchronous clear of pointers, count and flags
//   push_in      in   1       write din this cycle
//   pop_in       in   1       discard the head entry this cycle
//   din          in   DATA_W  write data
//   clr_err      in   1       clear sticky over_run / under_run
//   threshold    in   CNT_W   trigger level; 0 selects trigger-on-empty
//   dout         out  DATA_W  head entry (0 while empty)
//   count        out  CNT_W   occupancy, 0..DEPTH
//   empty        out  1       count == 0
//   full         out  1       count == DEPTH
//   over_run     out  1       sticky: push attempted while full
//   under_run    out  1       sticky: pop attempted while empty
//   thre_trigger out  1       fill-level trigger
//
// Push/pop handshake:
//   push_in and pop_in are single-cycle requests sampled on the rising edge
//   while en=1. There is no back-pressure output: the requester is expected to
//   look at full/empty first. A push against a full FIFO is dropped and
//   flagged unless a pop happens in the same cycle (the freed slot is reused);
//   a pop against an empty FIFO is ignored and flagged, even when a push
//   lands in the same cycle. Every output is a function of registered state
//   and threshold only, so there is no combinational path from a request to
//   an output.
// ---------------------------------------------------------------------------
module uart_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              push_in,
  input  logic              pop_in,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_err,
  input  logic [CNT_W-1:0]  threshold,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              over_run,
  output logic              under_run,
  output logic              thre_trigger
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LP_ZERO  = '0;
  localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] LP_PTR1  = PTR_W'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_over_run;
  logic              r_under_run;

  // -------------------------------------------------------------------------
  // Status decode (pure function of registered count)
  // -------------------------------------------------------------------------
  logic w_empty;
  logic w_full;

  assign w_empty = (r_count == LP_ZERO);
  assign w_full  = (r_count == LP_DEPTH);

  // -------------------------------------------------------------------------
  // Request qualification
  // -------------------------------------------------------------------------
  logic w_do_pop;
  logic w_do_push;
  logic w_set_ovr;
  logic w_set_udr;

  // A pop only happens if something is stored. A push is accepted when there
  // is room, or when a same-cycle pop frees the slot it writes into.
  assign w_do_pop  = en && pop_in && !w_empty;
  assign w_do_push = en && push_in && (!w_full || w_do_pop);

  // Error events are attempts that could not be honoured.
  assign w_set_ovr = en && push_in && w_full && !w_do_pop;
  assign w_set_udr = en && pop_in && w_empty;

  // -------------------------------------------------------------------------
  // Next-state computation
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_over_run_nxt;
  logic             w_under_run_nxt;

  always_comb begin
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_count_nxt     = r_count;
    w_over_run_nxt  = r_over_run;
    w_under_run_nxt = r_under_run;

    // Pointers are log2(DEPTH) wide, so the increment wraps on its own.
    if (w_do_push) begin
      w_wr_ptr_nxt = r_wr_ptr + LP_PTR1;
    end
    if (w_do_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + LP_PTR1;
    end

    unique case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + LP_ONE;
      2'b01:   w_count_nxt = r_count - LP_ONE;
      default: w_count_nxt = r_count;
    endcase

    // Clear first, then let a same-cycle set event override it.
    if (clr_err) begin
      w_over_run_nxt  = 1'b0;
      w_under_run_nxt = 1'b0;
    end
    if (w_set_ovr) begin
      w_over_run_nxt = 1'b1;
    end
    if (w_set_udr) begin
      w_under_run_nxt = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Control registers: reset has priority, flush behaves like reset
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_over_run  <= 1'b0;
      r_under_run <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_over_run  <= w_over_run_nxt;
      r_under_run <= w_under_run_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Storage: no reset, contents survive flush. The write is suppressed during
  // reset/flush so a flushed FIFO never sees a stray entry.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_do_push && !rst && !flush) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] w_head;
  logic              w_trigger;

  assign w_head = r_mem[r_rd_ptr];

  // threshold==0 selects trigger-on-empty; a threshold above DEPTH can never
  // be reached by count, so the trigger stays low without a special case.
  always_comb begin
    w_trigger = 1'b0;
    if (threshold == LP_ZERO) begin
      w_trigger = w_empty;
    end else begin
      w_trigger = (r_count >= threshold);
    end
  end

  assign dout         = w_empty ? '0 : w_head;
  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign over_run     = r_over_run;
  assign under_run    = r_under_run;
  assign thre_trigger = w_trigger;

endmodule
